bin_to_bcd: RTL

BIN_TO_BCD -- requirements
Module: bin_to_bcd

---
 rtl/bin_to_bcd.sv | 93 +++++++++
 1 files changed

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter using the double-dabble (shift-and-add-3) algorithm.
// One bit is processed per clock; a W-bit conversion takes W edges after start is accepted.
module bin_to_bcd #(
    parameter int unsigned W = 16,
    parameter int unsigned D = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   bin,
    output logic           busy,
    output logic           done,
    output logic [4*D-1:0] bcd
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     sr_q, sr_d;
    logic [4*D-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4*D-1:0]   bcd_q, bcd_d;
    logic             done_q, done_d;

    logic [4*D-1:0]   acc_adj;
    logic [4*D+W-1:0] shifted;

    // Add-3 correction on every digit in parallel, then one combined left shift.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(D); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {acc_adj, sr_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sr_d    = bin;
                    acc_d   = '0;
                    cnt_d   = CW'(W - 1);
                    state_d = StShift;
                end
            end
            StShift: begin
                acc_d = shifted[4*D+W-1:W];
                sr_d  = shifted[W-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    bcd_d   = shifted[4*D+W-1:W];
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule
